wb_req_master: RTL and testbench
================================

Name: wb_req_master

Overview:
- Wishbone classic master that feeds the SDRAM controller's Wishbone slave port.
- Accepts simple valid/ready read/write requests from the test sequencer or DSP datapath and buffers them in a small FIFO.
- Issues one single-beat Wishbone cycle per request, with cyc and stb rising and falling together.
- Returns read data or a write completion on a valid/ready response port.

Parameters:
- AW, 24, address width.
- DW, 32, data width; must be a multiple of 8.
- FIFO_DEPTH, 4, request FIFO entries; power of 2, ≥2.
- TIMEOUT_CYC, 256, ack wait limit in cycles; used only with WB_MASTER_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  FIFO not full.
- req_we_i  in  1  1=write, 0=read.
- req_addr_i  in  AW  request address.
- req_data_i  in  DW  write data.
- req_sel_i  in  DW/8  byte selects.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_data_o  out  DW  read data; 0 for writes and errors.
- rsp_err_o  out  1  cycle ended by err_i or timeout.
- cyc_o, stb_o  out  1  Wishbone cycle/strobe; always equal.
- we_o  out  1  Wishbone write enable.
- adr_o  out  AW  Wishbone address.
- dat_o  out  DW  Wishbone write data.
- sel_o  out  DW/8  Wishbone byte selects.
- dat_i  in  DW  Wishbone read data.
- ack_i  in  1  Wishbone acknowledge.
- err_i  in  1  Wishbone error.

Behaviour:
- Reset (rst_i=1 at posedge):
  - FIFO flushed.
  - FSM goes to IDLE.
  - cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, rsp_valid_o, rsp_data_o, rsp_err_o all 0.
  - req_ready_o=1 from the first cycle after reset.
  - Reset mid-cycle: cyc/stb are 0 the next cycle, and the in-flight request is discarded with no response.
- FIFO:
  - Push on req_valid_i & req_ready_o; req_ready_o = !full.
  - Pointers carry one extra wrap bit: full when pointers are equal and wrap bits differ.
  - Push to full is dropped (impossible under the handshake). Pop happens only on IDLE→BUS.
  - Simultaneous push and pop when full is not allowed, because req_ready_o=0.
- FSM, all outputs registered:
  - IDLE: if FIFO is not empty, pop the head, load we/adr/dat/sel registers, set cyc=stb=1, go to BUS.
  - BUS: cyc/stb/adr/dat/sel/we are held stable.
    - ack_i=1: capture dat_i for reads (0 for writes), set err=0, clear cyc=stb, go to RESP.
    - err_i=1: rsp_data=0, err=1, clear cyc=stb, go to RESP.
    - ack_i and err_i together: err wins.
  - RESP: rsp_valid_o=1; data and err are held until rsp_ready_i. On handshake, clear rsp_valid and go to IDLE.
- Latency:
  - Request accepted at edge N gives cyc/stb high from cycle N+1 at the earliest.
  - ack_i sampled at edge M gives cyc/stb low and rsp_valid_o=1 from cycle M+1.
- Cycle spacing: IDLE always lasts ≥1 cycle between transactions, so cyc/stb go low for ≥1 cycle between back-to-back cycles.
- ack_i or err_i outside BUS is ignored.
- we_o/adr_o/dat_o/sel_o keep their last values when cyc=0.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- Defined:
  - Counter, width $clog2(TIMEOUT_CYC+1), cleared on BUS entry and incremented each BUS cycle without ack/err.
  - On reaching TIMEOUT_CYC, terminate as for err_i: cyc/stb=0, rsp_err_o=1, rsp_data_o=0, go to RESP.
  - ack_i in the same cycle as terminal count: ack wins.
- Undefined: no counter; BUS waits indefinitely for ack_i/err_i.

Test Plan:
- Reset: hold rst_i=1 for 3 cycles with req_valid_i=1 → all outputs 0; after release req_ready_o=1 and no cycle is issued.
- Write: req we=1, addr 0x000010, data 0xDEADBEEF, sel 0xF; slave acks 2 cycles after stb → stb high 3 cycles with adr_o=0x10, dat_o=0xDEADBEEF throughout; then rsp_valid_o=1, rsp_err_o=0, rsp_data_o=0.
- Read: addr 0x000020, slave returns ack with dat_i=0x12345678 → rsp_data_o=0x12345678. With rsp_ready_i=0 for 5 cycles, the response is held and cyc stays 0.
- Back-to-back: 5 requests, ack held 0, timeout off → first in BUS, FIFO holds 4, req_ready_o=0. Then ack every cycle → 5 responses in order, with a cyc low gap ≥1 cycle between each.
- Error/timeout: err_i with ack_i in the same cycle → rsp_err_o=1. With WB_MASTER_TIMEOUT_EN and TIMEOUT_CYC=16, no ack → cyc drops after 16 BUS cycles, rsp_err_o=1, rsp_data_o=0.
- Reset mid-BUS: assert rst_i while cyc=1 → cyc/stb=0 next cycle, no rsp_valid_o, FIFO empty.

Source files
------------

// File: rtl/wb_req_master.sv
// rtl/wb_req_master.sv - Wishbone classic single-beat master behind a request FIFO
// Optional ack-wait timeout is compiled in with WB_MASTER_TIMEOUT_EN.
module wb_req_master #(
    parameter int AW          = 24,
    parameter int DW          = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [AW-1:0]   req_addr_i,
    input  logic [DW-1:0]   req_data_i,
    input  logic [DW/8-1:0] req_sel_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [DW-1:0]   rsp_data_o,
    output logic            rsp_err_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [AW-1:0]   adr_o,
    output logic [DW-1:0]   dat_o,
    output logic [DW/8-1:0] sel_o,
    input  logic [DW-1:0]   dat_i,
    input  logic            ack_i,
    input  logic            err_i
);

    localparam int SW = DW / 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + AW + DW + SW;

    if ((DW % 8) != 0 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("wb_req_master: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request FIFO; the extra pointer bit separates full from empty.
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr_q;
    logic [PW:0]   rd_ptr_q;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;
    logic          head_we;
    logic [AW-1:0] head_adr;
    logic [DW-1:0] head_dat;
    logic [SW-1:0] head_sel;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    assign push       = req_valid_i && !fifo_full;
    assign req_ready_o = !fifo_full;

    assign head     = fifo_mem[rd_ptr_q[PW-1:0]];
    assign head_we  = head[EW-1];
    assign head_adr = head[EW-2 -: AW];
    assign head_dat = head[DW+SW-1 -: DW];
    assign head_sel = head[SW-1:0];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PW-1:0]] <= {req_we_i, req_addr_i, req_data_i, req_sel_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            end
        end
    end

    state_t        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC);
    logic [TW-1:0] tmo_q, tmo_d;
    logic [TW-1:0] tmo_inc;

    assign tmo_inc = tmo_q + TW'(1);
`endif

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    we_d    = head_we;
                    adr_d   = head_adr;
                    dat_d   = head_dat;
                    sel_d   = head_sel;
                    cyc_d   = 1'b1;
                    state_d = BUS;
`ifdef WB_MASTER_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            BUS: begin
                // err has priority over a simultaneous ack.
                if (err_i) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = RESP;
                end else if (ack_i) begin
                    rsp_data_d  = we_q ? '0 : dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = RESP;
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (tmo_inc == TMO_LIMIT) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = RESP;
                end else begin
                    tmo_d = tmo_inc;
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign cyc_o       = cyc_q;
    assign stb_o       = cyc_q;
    assign we_o        = we_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    assign sel_o       = sel_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_req_master.sv
// tb/tb_wb_req_master.sv - self-checking bench for wb_req_master
module tb_wb_req_master;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_data_i;
    logic [SW-1:0] req_sel_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_data_o;
    logic          rsp_err_o;
    logic          cyc_o;
    logic          stb_o;
    logic          we_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic [SW-1:0] sel_o;
    logic [DW-1:0] dat_i;
    logic          ack_i;
    logic          err_i;

    always #5 clk_i = ~clk_i;

    wb_req_master #(
        .AW(AW), .DW(DW), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_sel_i(req_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
        int            delay;
        logic          err;
        logic          ack_too;
        logic [DW-1:0] rdata;
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } txn_t;

    txn_t slave_q[$];
    txn_t sb_q[$];
    txn_t cur;
    txn_t vec[7];
    txn_t t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   bcnt     = 0;
    int   last_hi  = 0;
    logic prev_term = 1'b0;
    logic slave_hold = 1'b0;
    logic stray_ack  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input txn_t tx);
        int n = 0;
        req_valid_i = 1'b1;
        req_we_i    = tx.we;
        req_addr_i  = tx.addr;
        req_data_i  = tx.data;
        req_sel_i   = tx.sel;
        while (!req_ready_o && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", 64'(n < 50), 64'd1);
        slave_q.push_back(tx);
        sb_q.push_back(tx);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int n = 0;
        while ((sb_q.size() != 0 || cyc_o || rsp_valid_o) && n < bound) begin
            tick();
            n++;
        end
        chk(nm, 64'(n < bound), 64'd1);
    endtask

    // Wishbone slave model: acks `delay` cycles after cyc rises, unless held.
    always @(negedge clk_i) begin
        logic term;
        term  = 1'b0;
        ack_i = 1'b0;
        err_i = 1'b0;
        dat_i = '0;
        if (prev_term) chk("cyc_drop_after_ack", 64'(cyc_o), 64'd0);
        if (cyc_o === 1'b1) begin
            if (bcnt == 0) begin
                if (slave_q.size() > 0) begin
                    cur = slave_q.pop_front();
                end else begin
                    chk("unexpected_cycle", 64'd1, 64'd0);
                    cur.delay = 1000000;
                end
            end
            chk("stb_eq_cyc", 64'(stb_o), 64'd1);
            chk("adr_o", 64'(adr_o), 64'(cur.addr));
            chk("we_o", 64'(we_o), 64'(cur.we));
            chk("dat_o", 64'(dat_o), 64'(cur.data));
            chk("sel_o", 64'(sel_o), 64'(cur.sel));
            if (!slave_hold && bcnt >= cur.delay) begin
                term  = 1'b1;
                dat_i = cur.rdata;
                err_i = cur.err;
                ack_i = cur.err ? cur.ack_too : 1'b1;
            end
            bcnt++;
        end else begin
            if (bcnt != 0) last_hi = bcnt;
            bcnt  = 0;
            ack_i = stray_ack;
            err_i = stray_ack;
            dat_i = {DW{stray_ack}};
        end
        prev_term = term;
    end

    // Response scoreboard.
    always @(negedge clk_i) begin
        txn_t e;
        if (rst_i === 1'b0 && rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_data", 64'(rsp_data_o), 64'(e.exp_data));
                chk("rsp_err", 64'(rsp_err_o), 64'(e.exp_err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired: got running expected finished");
        $fatal(1);
    end

    initial begin
        vec[0] = '{1'b1, 24'h000010, 32'hDEADBEEF, 4'hF, 2, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        vec[1] = '{1'b0, 24'h000020, 32'h0,        4'hF, 0, 1'b0, 1'b0, 32'h12345678, 32'h12345678, 1'b0};
        vec[2] = '{1'b0, 24'h000044, 32'h11111111, 4'h3, 3, 1'b0, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
        vec[3] = '{1'b0, 24'h000050, 32'h0,        4'hF, 1, 1'b1, 1'b0, 32'h55AA55AA, 32'h0,        1'b1};
        vec[4] = '{1'b1, 24'h000060, 32'h01020304, 4'h8, 0, 1'b1, 1'b1, 32'h0,        32'h0,        1'b1};
        vec[5] = '{1'b0, 24'hFFFFFC, 32'h0,        4'hF, 0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1};
        vec[6] = '{1'b1, 24'h000007, 32'h0,        4'h1, 1, 1'b0, 1'b0, 32'h00000BAD, 32'h0,        1'b0};

        rst_i       = 1'b1;
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 24'hABCDEF;
        req_data_i  = '1;
        req_sel_i   = '1;
        rsp_ready_i = 1'b1;
        repeat (3) tick();
        chk("rst_cyc", 64'(cyc_o), 64'd0);
        chk("rst_stb", 64'(stb_o), 64'd0);
        chk("rst_we", 64'(we_o), 64'd0);
        chk("rst_adr", 64'(adr_o), 64'd0);
        chk("rst_dat", 64'(dat_o), 64'd0);
        chk("rst_sel", 64'(sel_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data_o), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err_o), 64'd0);
        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        tick();
        chk("post_rst_ready", 64'(req_ready_o), 64'd1);
        repeat (3) tick();
        chk("post_rst_no_cycle", 64'(cyc_o), 64'd0);

        for (int i = 0; i < 7; i++) begin
            send(vec[i]);
            wait_idle("vec_done", 50);
            chk("vec_stb_cycles", 64'(last_hi), 64'(vec[i].delay + 1));
        end

        // Response back-pressure plus first-cycle latency.
        t = '{1'b0, 24'h000020, 32'h0, 4'hF, 1, 1'b0, 1'b0, 32'h12345678, 32'h12345678, 1'b0};
        rsp_ready_i = 1'b0;
        send(t);
        chk("lat_accept_edge", 64'(cyc_o), 64'd0);
        tick();
        chk("lat_next_edge", 64'(cyc_o), 64'd1);
        for (int n = 0; n < 20 && !rsp_valid_o; n++) tick();
        for (int k = 0; k < 5; k++) begin
            chk("held_valid", 64'(rsp_valid_o), 64'd1);
            chk("held_data", 64'(rsp_data_o), 64'h12345678);
            chk("held_cyc", 64'(cyc_o), 64'd0);
            tick();
        end
        rsp_ready_i = 1'b1;
        wait_idle("held_done", 20);

        // Fill FIFO behind a stalled bus cycle, then drain.
        slave_hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            t = '{1'b0, 24'h000100 + 24'(k), 32'(k), 4'hF, 0, 1'b0, 1'b0,
                  32'hA0000000 + 32'(k), 32'hA0000000 + 32'(k), 1'b0};
            send(t);
        end
        chk("b2b_full", 64'(req_ready_o), 64'd0);
        chk("b2b_bus", 64'(cyc_o), 64'd1);
        repeat (2) tick();
        chk("b2b_still_full", 64'(req_ready_o), 64'd0);
        slave_hold = 1'b0;
        wait_idle("b2b_done", 100);
        chk("b2b_ready_again", 64'(req_ready_o), 64'd1);

        // Stray ack/err outside a bus cycle.
        stray_ack = 1'b1;
        repeat (3) tick();
        stray_ack = 1'b0;
        chk("stray_no_rsp", 64'(rsp_valid_o), 64'd0);
        chk("stray_no_cyc", 64'(cyc_o), 64'd0);

        // Reset while a cycle is outstanding and another request is queued.
        slave_hold = 1'b1;
        t = '{1'b0, 24'h000300, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h1, 32'h1, 1'b0};
        send(t);
        send(t);
        for (int n = 0; n < 10 && !cyc_o; n++) tick();
        chk("mid_rst_pre_cyc", 64'(cyc_o), 64'd1);
        rst_i = 1'b1;
        tick();
        chk("mid_rst_cyc", 64'(cyc_o), 64'd0);
        chk("mid_rst_stb", 64'(stb_o), 64'd0);
        rst_i = 1'b0;
        sb_q.delete();
        slave_q.delete();
        slave_hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_rst_idle_cyc", 64'(cyc_o), 64'd0);
            chk("mid_rst_no_rsp", 64'(rsp_valid_o), 64'd0);
        end
        chk("mid_rst_ready", 64'(req_ready_o), 64'd1);

`ifdef WB_MASTER_TIMEOUT_EN
        t = '{1'b0, 24'h000400, 32'h0, 4'hF, 100000, 1'b0, 1'b0, 32'h77777777, 32'h0, 1'b1};
        send(t);
        wait_idle("tmo_done", 60);
        chk("tmo_stb_cycles", 64'(last_hi), 64'd16);
        chk("tmo_rsp_data", 64'(rsp_data_o), 64'd0);
        chk("tmo_rsp_err", 64'(rsp_err_o), 64'd1);
        slave_q.delete();
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
